// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-FF synchroniser, oversampled bit timing and a single-word valid/ready holding register.
// Optional UART_RX_MAJORITY_VOTE_EN: each bit is the 2-of-3 majority of three samples around mid-bit.
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W    = $clog2(OVERSAMPLE);
    localparam int BIT_W   = 4;

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST     = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  SAMPLE_TICK = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] DATA_LAST   = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST   = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q, prev_q;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [OS_W-1:0]      os_q, os_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 pacc_q, pacc_d;
    logic                 facc_q, facc_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    logic rx;
    logic tick;
    logic samp_stb;
    logic samp_bit;
    logic commit;
    logic commit_ferr;

    assign rx   = sync2_q;
    assign tick = (state_q != S_IDLE) && (div_q == DIV_LAST);

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [OS_W-1:0] PRE_TICK    = OS_W'(OVERSAMPLE / 2 - 2);
    localparam logic [OS_W-1:0] DECIDE_TICK = OS_W'(OVERSAMPLE / 2);

    logic smp_a_q, smp_a_d;
    logic smp_b_q, smp_b_d;

    // Third vote is the live line value at the decision tick.
    assign samp_stb = tick && (os_q == DECIDE_TICK);
    assign samp_bit = (smp_a_q & smp_b_q) | (smp_a_q & rx) | (smp_b_q & rx);

    always_comb begin
        smp_a_d = smp_a_q;
        smp_b_d = smp_b_q;
        if (tick && os_q == PRE_TICK)    smp_a_d = rx;
        if (tick && os_q == SAMPLE_TICK) smp_b_d = rx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_a_q <= 1'b1;
            smp_b_q <= 1'b1;
        end else begin
            smp_a_q <= smp_a_d;
            smp_b_q <= smp_b_d;
        end
    end
`else
    assign samp_stb = tick && (os_q == SAMPLE_TICK);
    assign samp_bit = rx;
`endif

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        pacc_d      = pacc_q;
        facc_d      = facc_q;
        commit      = 1'b0;
        commit_ferr = facc_q;
        case (state_q)
            S_IDLE: begin
                if (prev_q && !rx) begin
                    state_d = S_START;
                    bit_d   = '0;
                    pacc_d  = 1'b0;
                    facc_d  = 1'b0;
                end
            end
            S_START: begin
                // A line already back high at mid-bit was a glitch, not a start bit.
                if (samp_stb) state_d = samp_bit ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (samp_stb) begin
                    shreg_d = {samp_bit, shreg_q[DATA_BITS-1:1]};
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (samp_stb) begin
                    pacc_d  = ((^shreg_q) ^ samp_bit) != (PARITY == 1);
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (samp_stb) begin
                    facc_d = facc_q | ~samp_bit;
                    if (bit_q == STOP_LAST) begin
                        commit      = 1'b1;
                        commit_ferr = facc_q | ~samp_bit;
                        state_d     = samp_bit ? S_IDLE : S_BREAK;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_BREAK: begin
                if (rx) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counters sit at zero in IDLE so the sampling phase is locked to the start edge.
    always_comb begin
        div_d = div_q;
        os_d  = os_q;
        if (state_q == S_IDLE || state_d == S_IDLE) begin
            div_d = '0;
            os_d  = '0;
        end else if (tick) begin
            div_d = '0;
            os_d  = (os_q == OS_LAST) ? '0 : os_q + OS_W'(1);
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_comb begin
        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (valid_q && ready_i) valid_d = 1'b0;
        if (commit) begin
            if (!valid_q || ready_i) begin
                data_d  = shreg_q;
                perr_d  = pacc_q;
                ferr_d  = commit_ferr;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= S_IDLE;
            div_q   <= '0;
            os_q    <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            pacc_q  <= 1'b0;
            facc_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= data_i;
            sync2_q <= sync1_q;
            prev_q  <= rx;
            state_q <= state_d;
            div_q   <= div_d;
            os_q    <= os_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            pacc_q  <= pacc_d;
            facc_q  <= facc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign overrun_o    = ovr_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule
